conv_writeback: RTL
===================

CONV_WRITEBACK -- requirements
Module: conv_writeback

Interface
REQ-001 SHALL have parameters:
- DATA_WIDTH, default 8: output pixel width.
- ACC_WIDTH, default 20: signed convolution result width.
- SRAM_ADDR_WIDTH, default 4: output SRAM address width.
- FIFO_DEPTH, default 4: result buffer entries, power of two.

REQ-002 SHALL have ports, clock and reset first:
- i_clk  in  1  sole clock; all logic rising-edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse; begins a frame.
- i_count  in  SRAM_ADDR_WIDTH+1  results expected in the frame.
- i_base_addr  in  SRAM_ADDR_WIDTH  first write address.
- i_shift  in  5  arithmetic right-shift for requantisation.
- i_result_valid  in  1  upstream result valid.
- i_result_data  in  ACC_WIDTH  signed convolution result.
- o_result_ready  out  1  buffer can accept.
- o_sram_we  out  1  write strobe.
- o_sram_addr  out  SRAM_ADDR_WIDTH  write address.
- o_sram_wdata  out  DATA_WIDTH  write data.
- i_sram_ready  in  1  SRAM accepts write this cycle.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle frame-complete pulse.
- o_sat  out  1  sticky; a result saturated this frame.

Function
REQ-003 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-004 SHALL move IDLE->RUN on i_start; latch i_count, i_base_addr and i_shift; clear o_sat and the accepted/written counters.
REQ-005 SHALL ignore i_start when not in IDLE.
REQ-006 SHALL go IDLE->DONE directly when i_start arrives with i_count==0.
REQ-007 SHALL accept a result when i_result_valid && o_result_ready.
REQ-008 SHALL drive o_result_ready=1 only in RUN, with FIFO not full and accepted count < latched count.
REQ-009 SHALL move RUN->DRAIN in the cycle the accepted count reaches the latched count.
REQ-010 SHALL move DRAIN->DONE once the written count equals the latched count.
REQ-011 SHALL move DONE->IDLE after exactly one cycle, with o_done=1 in that cycle only.
REQ-012 SHALL store results in a FIFO_DEPTH-entry FIFO with wrapping pointers.
REQ-013 SHALL allow simultaneous push and pop when full; occupancy is then unchanged.
REQ-014 SHALL compute each write word from the FIFO head: arithmetic right-shift of the signed result by the latched shift.
REQ-015 SHALL saturate the shifted value to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and set o_sat on any clipping.
REQ-016 SHALL register o_sram_we/addr/wdata, giving one cycle of latency from FIFO head to strobe.
REQ-017 SHALL hold o_sram_we, addr and wdata stable while i_sram_ready=0.
REQ-018 SHALL complete a write only in a cycle with o_sram_we && i_sram_ready.
REQ-019 SHALL write to address base+n for the n-th result, wrapping modulo 2^SRAM_ADDR_WIDTH.
REQ-020 SHALL never issue more writes than the latched count.
REQ-021 SHALL drive o_busy=1 in RUN and DRAIN, and 0 otherwise.

Reset
REQ-022 SHALL, on i_rst low, asynchronously force IDLE and clear all of: FIFO pointers and occupancy, both counters, o_result_ready, o_sram_we, o_sram_addr, o_sram_wdata, o_busy, o_done and o_sat.
REQ-023 SHALL abandon a frame in progress on reset mid-frame, with no write strobe in the first cycle after release.

Configuration
REQ-024 SHALL, with macro CONV_WRITEBACK_RELU_EN defined, clamp negative shifted values to 0 before saturation; clamping to 0 SHALL NOT set o_sat.
REQ-025 SHALL, without CONV_WRITEBACK_RELU_EN, pass negative values through signed saturation unchanged.

Verification
REQ-026 Basic frame: count=3, base=2, shift=0, results 5,6,7 back-to-back, sram_ready=1 -> writes (2,5),(3,6),(4,7); o_done one cycle after the last write; o_sat=0.
REQ-027 Saturation: shift=2, result 1000 -> wdata 127, o_sat=1. Result -1000 -> wdata 0x80 without RELU_EN, 0x00 with it.
REQ-028 Backpressure: i_sram_ready=0 for 10 cycles, count=6 -> o_result_ready drops after 4 accepts plus one in the output register; write outputs stay stable; all 6 written in order after release.
REQ-029 Wrap: base=14, count=4 -> addresses 14,15,0,1.
REQ-030 Edge starts: i_start with count=0 -> o_done next cycle, no writes. i_start during RUN -> ignored.
REQ-031 Reset mid-frame: i_rst low after 2 of 5 writes -> all outputs 0 and state IDLE; a new frame afterwards behaves as REQ-026.

Source files
------------

// File: rtl/conv_writeback.sv
// Convolution result writeback: buffers signed accumulator results, requantises them
// (shift + saturate) and streams them to an output SRAM. Optional ReLU: CONV_WRITEBACK_RELU_EN.
module conv_writeback #(
    parameter int DATA_WIDTH      = 8,
    parameter int ACC_WIDTH       = 20,
    parameter int SRAM_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [SRAM_ADDR_WIDTH:0]   i_count,
    input  logic [SRAM_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [4:0]                 i_shift,
    input  logic                       i_result_valid,
    input  logic [ACC_WIDTH-1:0]       i_result_data,
    output logic                       o_result_ready,
    output logic                       o_sram_we,
    output logic [SRAM_ADDR_WIDTH-1:0] o_sram_addr,
    output logic [DATA_WIDTH-1:0]      o_sram_wdata,
    input  logic                       i_sram_ready,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_sat
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = SRAM_ADDR_WIDTH + 1;
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   OCC_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_r, state_s;

    logic [CNT_W-1:0]           count_r, acc_cnt_r, wr_cnt_r, iss_cnt_r;
    logic [SRAM_ADDR_WIDTH-1:0] base_r;
    logic [4:0]                 shift_r;

    logic signed [ACC_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]              occ_r;

    logic                        start_s, push_s, pop_s, wdone_s, full_s, ready_s;
    logic signed [ACC_WIDTH-1:0] head_s;
    logic [DATA_WIDTH:0]         quant_s;

    // Saturating requantisation; MSB of the result flags a clipped value.
    function automatic logic [DATA_WIDTH:0] requant(input logic signed [ACC_WIDTH-1:0] v);
        logic signed [ACC_WIDTH-1:0] c;
        c = v;
`ifdef CONV_WRITEBACK_RELU_EN
        if (c[ACC_WIDTH-1]) begin
            c = '0;
        end else begin
            c = v;
        end
`endif
        if (c > SAT_MAX) begin
            requant = {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
        end else if (c < SAT_MIN) begin
            requant = {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
        end else begin
            requant = {1'b0, c[DATA_WIDTH-1:0]};
        end
    endfunction

    assign start_s = (state_r == IDLE) && i_start;
    assign full_s  = (occ_r == DEPTH_C);
    assign wdone_s = o_sram_we && i_sram_ready;
    // The output register frees up whenever it is empty or its word is being taken.
    assign pop_s   = ((state_r == RUN) || (state_r == DRAIN)) && (occ_r != '0) &&
                     (!o_sram_we || i_sram_ready);
    assign ready_s = (state_r == RUN) && (acc_cnt_r < count_r) && (!full_s || pop_s);
    assign push_s  = i_result_valid && ready_s;
    assign head_s  = fifo_mem[rd_ptr_r] >>> shift_r;
    assign quant_s = requant(head_s);
    assign o_result_ready = ready_s;

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_s = (i_count == '0) ? DONE : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (push_s && ((acc_cnt_r + CNT_ONE) == count_r)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if ((wr_cnt_r + CNT_W'(wdone_s)) == count_r) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register with registered status flags.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r <= IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_r <= state_s;
            o_busy  <= (state_s == RUN) || (state_s == DRAIN);
            o_done  <= (state_s == DONE);
        end
    end

    // Frame parameters, progress counters and sticky saturation flag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            count_r   <= '0;
            base_r    <= '0;
            shift_r   <= '0;
            acc_cnt_r <= '0;
            wr_cnt_r  <= '0;
            iss_cnt_r <= '0;
            o_sat     <= 1'b0;
        end else if (start_s) begin
            count_r   <= i_count;
            base_r    <= i_base_addr;
            shift_r   <= i_shift;
            acc_cnt_r <= '0;
            wr_cnt_r  <= '0;
            iss_cnt_r <= '0;
            o_sat     <= 1'b0;
        end else begin
            if (push_s)  acc_cnt_r <= acc_cnt_r + CNT_ONE;
            if (wdone_s) wr_cnt_r  <= wr_cnt_r + CNT_ONE;
            if (pop_s)   iss_cnt_r <= iss_cnt_r + CNT_ONE;
            if (pop_s && quant_s[DATA_WIDTH]) o_sat <= 1'b1;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (push_s) fifo_mem[wr_ptr_r] <= $signed(i_result_data);
    end

    // Write port register: loads from the FIFO head, holds while the SRAM stalls.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_sram_we    <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
        end else if (pop_s) begin
            o_sram_we    <= 1'b1;
            o_sram_addr  <= base_r + iss_cnt_r[SRAM_ADDR_WIDTH-1:0];
            o_sram_wdata <= quant_s[DATA_WIDTH-1:0];
        end else if (i_sram_ready) begin
            o_sram_we    <= 1'b0;
        end
    end

endmodule
